// File: rtl/strat_order_sched.sv
// Order sequencer: turns one-cycle buy/sell decisions into held, handshaked orders
// with a symmetric position limit, a post-order cooldown and a saturating drop counter.
module strat_order_sched #(
    parameter int W        = 32,
    parameter int QW       = 16,
    parameter int COOLDOWN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          sig_valid,
    input  logic          buy,
    input  logic          sell,
    input  logic [W-1:0]  bid_px0,
    input  logic [W-1:0]  ask_px0,
    input  logic [QW-1:0] order_qty,
    input  logic [QW-1:0] pos_limit,
    input  logic          ord_ready,
    output logic          ord_valid,
    output logic          ord_side,
    output logic [W-1:0]  ord_px,
    output logic [QW-1:0] ord_qty,
    output logic [QW-1:0] position,
    output logic [15:0]   drop_cnt,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : {CW{1'b0}};

    logic [1:0]    r_state;
    logic [CW-1:0] r_cool_cnt;
    logic          r_ord_valid;
    logic          r_ord_side;
    logic [W-1:0]  r_ord_px;
    logic [QW-1:0] r_ord_qty;
    logic [QW-1:0] r_position;
    logic [15:0]   r_drop_cnt;
    logic          r_busy;

    logic                 w_act;
    logic                 w_conf;
    logic                 w_pass;
    logic                 w_drop;
    logic                 w_transfer;
    logic [15:0]          w_drop_nxt;
    logic signed [QW+1:0] w_pos_x;
    logic signed [QW+1:0] w_qty_x;
    logic signed [QW+1:0] w_lim_x;

    assign w_act      = sig_valid & enable & (buy ^ sell);
    assign w_conf     = sig_valid & enable & buy & sell;
    assign w_transfer = r_ord_valid & ord_ready;

    // Limit check and drop decision; two guard bits keep the signed sums exact.
    always_comb begin
        w_pos_x = {{2{r_position[QW-1]}}, r_position};
        w_qty_x = {2'b00, order_qty};
        w_lim_x = {2'b00, pos_limit};
        if (buy) begin
            w_pass = ((w_pos_x + w_qty_x) <= w_lim_x);
        end else begin
            w_pass = ((w_pos_x - w_qty_x) >= -w_lim_x);
        end
        case (r_state)
            S_IDLE:  w_drop = w_conf | (w_act & ~w_pass);
            default: w_drop = w_act | w_conf;
        endcase
        if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            w_drop_nxt = r_drop_cnt + 16'd1;
        end else begin
            w_drop_nxt = r_drop_cnt;
        end
    end

    // Sequencer state, latched order payload, position and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cool_cnt  <= {CW{1'b0}};
            r_ord_valid <= 1'b0;
            r_ord_side  <= 1'b0;
            r_ord_px    <= {W{1'b0}};
            r_ord_qty   <= {QW{1'b0}};
            r_position  <= {QW{1'b0}};
            r_drop_cnt  <= 16'd0;
            r_busy      <= 1'b0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_act && w_pass) begin
                        r_state     <= S_HOLD;
                        r_ord_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_ord_side  <= buy;
                        r_ord_px    <= buy ? ask_px0 : bid_px0;
                        r_ord_qty   <= order_qty;
                    end
                end
                S_HOLD: begin
                    if (w_transfer) begin
                        r_ord_valid <= 1'b0;
                        r_position  <= r_ord_side ? (r_position + r_ord_qty)
                                                  : (r_position - r_ord_qty);
                        if (COOLDOWN == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_COOL;
                            r_cool_cnt <= CNT_LOAD;
                        end
                    end
                end
                S_COOL: begin
                    if (r_cool_cnt == {CW{1'b0}}) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cool_cnt <= r_cool_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ord_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign ord_valid = r_ord_valid;
    assign ord_side  = r_ord_side;
    assign ord_px    = r_ord_px;
    assign ord_qty   = r_ord_qty;
    assign position  = r_position;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = r_busy;

endmodule
